// File: rtl/uwasic_onboarding_spi_pwm_pkg.sv
// Shared constants and frame layout for the SPI-controlled PWM tile.
// Included by the SPI register file and by the top level.
package uwasic_onboarding_spi_pwm_pkg;

    localparam int ADDR_W     = 7;
    localparam int FRAME_BITS = 16;
    localparam int CNT_W      = 5;

    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;
    localparam logic [ADDR_W-1:0] MAX_ADDR       = 7'd4;

    // The bit counter stops one past a full frame, so long frames stay distinguishable.
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } frame_t;

    function automatic logic frame_ok(input frame_t f, input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_FULL) && f.wr && (f.addr <= MAX_ADDR);
    endfunction

endpackage

// File: rtl/uwasic_onboarding_spi_pwm_if.sv
// Tiny Tapeout tile pin bundle: the DUT sees it through the slave modport,
// the harness drives it through the master modport.
interface uwasic_onboarding_spi_pwm_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/uwasic_onboarding_spi_pwm_spi_peripheral.sv
// Write-only mode-0 SPI slave: synchronizes the pins, assembles 16-bit frames
// and commits valid writes into the five-byte register file on nCS release.
module uwasic_onboarding_spi_pwm_spi_peripheral
    import uwasic_onboarding_spi_pwm_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        copi,
    input  logic        ncs,
    output logic [15:0] en_out,
    output logic [15:0] en_pwm,
    output logic [7:0]  duty
);

    logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
    logic                   sclk_d, ncs_d;
    logic                   sclk_s, copi_s, ncs_s;
    logic                   sclk_rise, ncs_fall, ncs_rise;
    logic [FRAME_BITS-1:0]  shreg;
    logic [CNT_W-1:0]       cnt;
    frame_t                 frame;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign ncs_fall  = ~ncs_s & ncs_d;
    assign ncs_rise  = ncs_s & ~ncs_d;
    assign frame     = frame_t'(shreg);

    // Synchronizer chains plus one delay stage for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '0;
            sclk_d    <= 1'b0;
            ncs_d     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            sclk_d    <= sclk_s;
            ncs_d     <= ncs_s;
        end
    end

    // Frame assembly, MSB first
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (ncs_fall) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (!ncs_s && sclk_rise) begin
            shreg <= {shreg[FRAME_BITS-2:0], copi_s};
            cnt   <= (cnt == CNT_SAT) ? CNT_SAT : cnt + 1'b1;
        end
    end

    // Register file commit on nCS release
    always_ff @(posedge clk) begin
        if (rst) begin
            en_out <= '0;
            en_pwm <= '0;
            duty   <= '0;
        end else if (ncs_rise && frame_ok(frame, cnt)) begin
            case (frame.addr)
                ADDR_EN_OUT_LO: en_out[7:0]  <= frame.data;
                ADDR_EN_OUT_HI: en_out[15:8] <= frame.data;
                ADDR_EN_PWM_LO: en_pwm[7:0]  <= frame.data;
                ADDR_EN_PWM_HI: en_pwm[15:8] <= frame.data;
                ADDR_DUTY:      duty         <= frame.data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uwasic_onboarding_spi_pwm.sv
// Tile top: SPI register file, one shared 8-bit PWM generator and the
// per-pin enable / PWM-select output mux.
module uwasic_onboarding_spi_pwm
    import uwasic_onboarding_spi_pwm_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int PWM_PRESCALE = 13
) (
    input  logic                          clk,
    input  logic                          rst_n,
    uwasic_onboarding_spi_pwm_if.slave    io
);

    localparam int             PW        = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(PWM_PRESCALE - 1);

    logic [15:0]   en_out, en_pwm;
    logic [7:0]    duty;
    logic [PW-1:0] presc;
    logic [7:0]    pwm_cnt;
    logic          pwm;
    logic [15:0]   pins;
    logic          unused_in;

    // rst_n keeps its historical name but is an active-high reset
    uwasic_onboarding_spi_pwm_spi_peripheral #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_spi (
        .clk    (clk),
        .rst    (rst_n),
        .sclk   (io.ui_in[0]),
        .copi   (io.ui_in[1]),
        .ncs    (io.ui_in[2]),
        .en_out (en_out),
        .en_pwm (en_pwm),
        .duty   (duty)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else if (presc == PRESC_MAX) begin
            presc   <= '0;
            pwm_cnt <= pwm_cnt + 8'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Full scale forces a solid high; otherwise a 255/256 duty would leave one low tick
    assign pwm = (duty == 8'hFF) || (pwm_cnt < duty);

    always_ff @(posedge clk) begin
        if (rst_n) pins <= '0;
        else       pins <= en_out & (~en_pwm | {16{pwm}});
    end

    assign io.uo_out  = pins[7:0];
    assign io.uio_out = pins[15:8];
    assign io.uio_oe  = 8'hFF;
    assign unused_in  = &{1'b0, io.ena, io.uio_in, io.ui_in[7:3]};

endmodule

// File: tb/tb_uwasic_onboarding_spi_pwm.sv
// Directed bench for the SPI-controlled PWM tile: register writes, discarded
// frames, PWM timing, constant duty extremes and reset during a frame.
module tb_uwasic_onboarding_spi_pwm;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic sclk = 1'b0;
    logic copi = 1'b0;
    logic ncs = 1'b1;

    int checks = 0;
    int errors = 0;

    uwasic_onboarding_spi_pwm_if ifc ();

    assign ifc.ui_in  = {5'b0, ncs, copi, sclk};
    assign ifc.uio_in = 8'h00;
    assign ifc.ena    = 1'b1;

    uwasic_onboarding_spi_pwm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (ifc)
    );

    always #50 clk = ~clk;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic spi_bits(input logic [31:0] word, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = word[i];
            wait_clk(4);
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_send(input logic [31:0] word, input int nbits);
        ncs = 1'b0;
        wait_clk(4);
        spi_bits(word, nbits);
        wait_clk(4);
        ncs = 1'b1;
        wait_clk(8);
    endtask

    task automatic pwm_measure(output int high_t, output int period_t, output bit timeout);
        int n;
        timeout  = 1'b0;
        high_t   = 0;
        period_t = 0;
        n = 0;
        while (ifc.uo_out[0] !== 1'b0 && n < 10000) begin wait_clk(1); n++; end
        if (n >= 10000) timeout = 1'b1;
        n = 0;
        while (ifc.uo_out[0] !== 1'b1 && n < 10000) begin wait_clk(1); n++; end
        if (n >= 10000) timeout = 1'b1;
        while (ifc.uo_out[0] === 1'b1 && high_t < 10000) begin wait_clk(1); high_t++; end
        period_t = high_t;
        while (ifc.uo_out[0] === 1'b0 && period_t < 20000) begin wait_clk(1); period_t++; end
    endtask

    task automatic count_high(input int cycles, output int highs);
        highs = 0;
        for (int i = 0; i < cycles; i++) begin
            wait_clk(1);
            if (ifc.uo_out[0] === 1'b1) highs++;
        end
    endtask

    int  hi_t, per_t, highs;
    bit  tmo;

    initial begin
        // Reset
        wait_clk(5);
        check("reset_uo_out", 32'(ifc.uo_out), 32'h00);
        check("reset_uio_out", 32'(ifc.uio_out), 32'h00);
        check("reset_uio_oe", 32'(ifc.uio_oe), 32'hFF);
        rst_n = 1'b0;
        wait_clk(4);

        // Basic writes and a read frame
        spi_send(32'h80F0, 16);
        check("wr_en_out_lo", 32'(ifc.uo_out), 32'hF0);
        spi_send(32'h81CC, 16);
        check("wr_en_out_hi", 32'(ifc.uio_out), 32'hCC);
        spi_send(32'h0030, 16);
        check("read_uo_out", 32'(ifc.uo_out), 32'hF0);
        check("read_uio_out", 32'(ifc.uio_out), 32'hCC);

        // Discarded frames
        spi_send(32'h8530, 16);
        check("bad_addr_uo_out", 32'(ifc.uo_out), 32'hF0);
        check("bad_addr_uio_out", 32'(ifc.uio_out), 32'hCC);
        spi_send(32'h8012 >> 1, 15);
        check("short_frame", 32'(ifc.uo_out), 32'hF0);
        spi_send({15'd0, 16'h8012, 1'b0}, 17);
        check("long_frame", 32'(ifc.uo_out), 32'hF0);

        // PWM at half duty on pin 0
        spi_send(32'h80F1, 16);
        spi_send(32'h8201, 16);
        spi_send(32'h8480, 16);
        pwm_measure(hi_t, per_t, tmo);
        check("pwm_timeout", 32'(tmo), 32'h0);
        check_range("pwm_high", hi_t, 1664 - 13, 1664 + 13);
        check_range("pwm_period", per_t, 3328 - 1, 3328 + 1);
        check("pwm_other_pins", 32'(ifc.uo_out[7:1]), 32'h78);
        check("pwm_uio_out", 32'(ifc.uio_out), 32'hCC);

        // Duty extremes and output disable
        spi_send(32'h8400, 16);
        count_high(2 * 3328, highs);
        check("duty_00_highs", 32'(highs), 32'd0);
        spi_send(32'h84FF, 16);
        count_high(2 * 3328, highs);
        check("duty_ff_highs", 32'(highs), 32'(2 * 3328));
        spi_send(32'h80F0, 16);
        check("pin0_disabled", 32'(ifc.uo_out), 32'hF0);

        // Reset in the middle of a frame
        ncs = 1'b0;
        wait_clk(4);
        spi_bits(32'h81, 8);
        rst_n = 1'b1;
        wait_clk(2);
        rst_n = 1'b0;
        wait_clk(4);
        ncs = 1'b1;
        wait_clk(8);
        check("midrst_uo_out", 32'(ifc.uo_out), 32'h00);
        check("midrst_uio_out", 32'(ifc.uio_out), 32'h00);
        spi_send(32'h8055, 16);
        check("after_rst_uo_out", 32'(ifc.uo_out), 32'h55);
        check("after_rst_uio_out", 32'(ifc.uio_out), 32'h00);
        check("after_rst_uio_oe", 32'(ifc.uio_oe), 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
